// File: rtl/systolic_stream_collector.sv
// Captures one M_ROWS x N_COLS result matrix from the systolic array stream, then drains it row-major over valid/ready.
// Optional idle-beat watchdog in COLLECT is enabled by defining SA_COLLECT_TIMEOUT_EN.
module systolic_stream_collector #(
    parameter int DATA_WIDTH     = 16,
    parameter int M_ROWS         = 5,
    parameter int N_COLS         = 5,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int RW = (M_ROWS > 1) ? $clog2(M_ROWS) : 1,
    localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  clr_i,
    output logic                  start_stream_o,
    output logic                  stream_clr_o,
    input  logic                  stream_valid_i,
    input  logic [DATA_WIDTH-1:0] stream_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [RW-1:0]         rd_row_o,
    output logic [CW-1:0]         rd_col_o,
    output logic                  err_o
);

    // state   | meaning
    // IDLE    | waiting for req_i
    // START   | start_stream_o pulse to the array
    // COLLECT | capturing stream beats row-major
    // DRAIN   | presenting captured elements on the read port
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_COLLECT = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    localparam logic [RW-1:0] ROW_LAST = RW'(M_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] wr_row_q, wr_row_d, rd_row_q, rd_row_d;
    logic [CW-1:0] wr_col_q, wr_col_d, rd_col_q, rd_col_d;
    logic          done_q, done_d;
    logic          sclr_q, sclr_d;
    logic          wr_en;
    logic          abort;
    logic          timeout;

    logic [DATA_WIDTH-1:0] mem_q [M_ROWS][N_COLS];

`ifdef SA_COLLECT_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] IDLE_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] idle_q, idle_d;
    logic          err_q, err_d;

    // Down-counter reloads on COLLECT entry and every beat; hitting zero on an idle cycle is the timeout.
    always_comb begin
        idle_d = idle_q;
        if (state_q == S_START || (state_q == S_COLLECT && stream_valid_i)) begin
            idle_d = IDLE_LOAD;
        end else if (state_q == S_COLLECT && idle_q != '0) begin
            idle_d = idle_q - 1'b1;
        end
    end

    assign timeout = (state_q == S_COLLECT) && !stream_valid_i && (idle_q == '0);

    always_comb begin
        err_d = err_q;
        if (state_q == S_IDLE && req_i) begin
            err_d = 1'b0;
        end
        if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idle_q <= '0;
            err_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        wr_row_d = wr_row_q;
        wr_col_d = wr_col_q;
        rd_row_d = rd_row_q;
        rd_col_d = rd_col_q;
        done_d   = 1'b0;
        sclr_d   = 1'b0;
        wr_en    = 1'b0;
        abort    = timeout || (clr_i && state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (stream_valid_i) begin
                    wr_en = 1'b1;
                    if (wr_col_q == COL_LAST) begin
                        wr_col_d = '0;
                        if (wr_row_q == ROW_LAST) begin
                            wr_row_d = '0;
                            state_d  = S_DRAIN;
                            done_d   = 1'b1;
                        end else begin
                            wr_row_d = wr_row_q + 1'b1;
                        end
                    end else begin
                        wr_col_d = wr_col_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (rd_ready_i) begin
                    if (rd_col_q == COL_LAST) begin
                        rd_col_d = '0;
                        if (rd_row_q == ROW_LAST) begin
                            rd_row_d = '0;
                            state_d  = S_IDLE;
                        end else begin
                            rd_row_d = rd_row_q + 1'b1;
                        end
                    end else begin
                        rd_col_d = rd_col_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything, including a final beat landing in the same cycle.
        if (abort) begin
            state_d  = S_IDLE;
            wr_row_d = '0;
            wr_col_d = '0;
            rd_row_d = '0;
            rd_col_d = '0;
            done_d   = 1'b0;
            sclr_d   = 1'b1;
            wr_en    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            wr_row_q <= '0;
            wr_col_q <= '0;
            rd_row_q <= '0;
            rd_col_q <= '0;
            done_q   <= 1'b0;
            sclr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_row_q <= wr_row_d;
            wr_col_q <= wr_col_d;
            rd_row_q <= rd_row_d;
            rd_col_q <= rd_col_d;
            done_q   <= done_d;
            sclr_q   <= sclr_d;
        end
    end

    // Result buffer carries no reset; contents are only meaningful after a full capture.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_row_q][wr_col_q] <= stream_data_i;
        end
    end

    assign start_stream_o = (state_q == S_START);
    assign stream_clr_o   = sclr_q;
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = done_q;
    assign rd_valid_o     = (state_q == S_DRAIN);
    assign rd_data_o      = rd_valid_o ? mem_q[rd_row_q][rd_col_q] : '0;
    assign rd_row_o       = rd_row_q;
    assign rd_col_o       = rd_col_q;

endmodule

// File: tb/tb_systolic_stream_collector.sv
// Randomized self-checking bench for systolic_stream_collector (5x5, 16-bit, timeout 8 when enabled).
module tb_systolic_stream_collector;

    localparam int M = 5;
    localparam int N = 5;
    localparam int E = M * N;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_i = 1'b0;
    logic        clr_i = 1'b0;
    logic        start_stream_o, stream_clr_o;
    logic        stream_valid_i = 1'b0;
    logic [15:0] stream_data_i = '0;
    logic        busy_o, done_o, rd_valid_o;
    logic        rd_ready_i = 1'b0;
    logic [15:0] rd_data_o;
    logic [2:0]  rd_row_o, rd_col_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    int n_start = 0;
    int n_done  = 0;
    int n_sclr  = 0;

    // Expected matrix in row-major order; element k lives at (k/N, k%N).
    logic [15:0] exp_mat [E];

    systolic_stream_collector #(
        .DATA_WIDTH(16), .M_ROWS(M), .N_COLS(N), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .clr_i(clr_i),
        .start_stream_o(start_stream_o), .stream_clr_o(stream_clr_o),
        .stream_valid_i(stream_valid_i), .stream_data_i(stream_data_i),
        .busy_o(busy_o), .done_o(done_o), .rd_valid_o(rd_valid_o),
        .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
        .rd_row_o(rd_row_o), .rd_col_o(rd_col_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (start_stream_o === 1'b1) n_start++;
        if (done_o === 1'b1)         n_done++;
        if (stream_clr_o === 1'b1)   n_sclr++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Full collection + drain; gap=g gives one beat every g cycles, rdmode 0=ready,1=1010,2=random.
    task automatic run_matrix(input int gap, input int rdmode, input bit hold_req, input bit stray);
        int s0, d0, c, beat, k, guard;
        bit rdy;
        s0 = n_start;
        d0 = n_done;
        req_i = 1'b1;
        step();
        checks++;
        if (start_stream_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse got start=%b busy=%b exp 1 1", start_stream_o, busy_o);
        end
        if (!hold_req) req_i = 1'b0;
        step();
        c = 0;
        beat = 0;
        while (beat < E) begin
            if (gap > 1 && (c % gap) != gap - 1) begin
                stream_valid_i = 1'b0;
                stream_data_i  = 16'($urandom);
            end else begin
                stream_valid_i = 1'b1;
                stream_data_i  = exp_mat[beat];
                beat++;
            end
            step();
            c++;
        end
        stream_valid_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || rd_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL drain_entry got done=%b rd_valid=%b exp 1 1", done_o, rd_valid_o);
        end
        k = 0;
        guard = 0;
        while (k < E && guard < 400) begin
            case (rdmode)
                0:       rdy = 1'b1;
                1:       rdy = (guard % 2) == 0;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            rd_ready_i = rdy;
            if (stray) begin
                stream_valid_i = 1'($urandom_range(0, 1));
                stream_data_i  = 16'($urandom);
            end
            checks++;
            if (rd_valid_o !== 1'b1 || rd_data_o !== exp_mat[k] ||
                rd_row_o !== 3'(k / N) || rd_col_o !== 3'(k % N)) begin
                errors++;
                $display("FAIL read[%0d] got v=%b d=%h r=%0d c=%0d exp v=1 d=%h r=%0d c=%0d",
                         k, rd_valid_o, rd_data_o, rd_row_o, rd_col_o, exp_mat[k], k / N, k % N);
            end
            step();
            if (rdy) k++;
            guard++;
        end
        req_i = 1'b0;
        rd_ready_i = 1'b0;
        stream_valid_i = 1'b0;
        checks++;
        if (k != E) begin
            errors++;
            $display("FAIL drain_budget got %0d reads exp %0d", k, E);
        end
        checks++;
        if (busy_o !== 1'b0 || rd_valid_o !== 1'b0 || rd_data_o !== 16'h0) begin
            errors++;
            $display("FAIL back_to_idle got busy=%b rd_valid=%b rd_data=%h exp 0 0 0",
                     busy_o, rd_valid_o, rd_data_o);
        end
        checks++;
        if (n_start - s0 != 1 || n_done - d0 != 1) begin
            errors++;
            $display("FAIL pulse_count got start=%0d done=%0d exp 1 1", n_start - s0, n_done - d0);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        stream_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stream_data_i = 16'($urandom);
            step();
        end
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            stream_data_i = 16'($urandom);
            step();
            checks++;
            if ({start_stream_o, stream_clr_o, busy_o, done_o, rd_valid_o, err_o} !== 6'b0 ||
                rd_data_o !== 16'h0 || rd_row_o !== 3'd0 || rd_col_o !== 3'd0) begin
                errors++;
                $display("FAIL reset_idle got st=%b sc=%b busy=%b done=%b v=%b err=%b d=%h exp all 0",
                         start_stream_o, stream_clr_o, busy_o, done_o, rd_valid_o, err_o, rd_data_o);
            end
        end
        stream_valid_i = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < E; i++) exp_mat[i] = 16'(i + 1);
        run_matrix(1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_gapped_backpressure();
        for (int i = 0; i < E; i++) exp_mat[i] = 16'(i + 1);
        run_matrix(3, 1, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        int d0, s0;
        d0 = n_done;
        s0 = n_sclr;
        req_i = 1'b1;
        step();
        req_i = 1'b0;
        step();
        for (int i = 0; i < 7; i++) begin
            stream_valid_i = 1'b1;
            stream_data_i  = 16'($urandom);
            step();
        end
        stream_valid_i = 1'b0;
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || stream_clr_o !== 1'b1 || rd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_exit got busy=%b stream_clr=%b rd_valid=%b exp 0 1 0",
                     busy_o, stream_clr_o, rd_valid_o);
        end
        step();
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        step();
        checks++;
        if (n_sclr - s0 != 1 || n_done != d0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulses got stream_clr=%0d done=%0d busy=%b exp 1 0 0",
                     n_sclr - s0, n_done - d0, busy_o);
        end
        for (int i = 0; i < E; i++) exp_mat[i] = 16'(100 + i);
        run_matrix(1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_stray_requests();
        for (int i = 0; i < E; i++) exp_mat[i] = 16'($urandom);
        run_matrix(2, 2, 1'b1, 1'b1);
    endtask

    task automatic test_random_back_to_back();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < E; i++) exp_mat[i] = 16'($urandom);
            run_matrix(int'($urandom_range(1, 4)), 2, 1'b0, 1'b0);
        end
    endtask

    task automatic test_mid_reset();
        req_i = 1'b1;
        step();
        req_i = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            stream_valid_i = 1'b1;
            stream_data_i  = 16'($urandom);
            step();
        end
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0 || start_stream_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got busy=%b start=%b done=%b exp 0 0 0", busy_o, start_stream_o, done_o);
        end
        step();
        rst_i = 1'b0;
        stream_valid_i = 1'b0;
        step();
        for (int i = 0; i < E; i++) exp_mat[i] = 16'(200 + i);
        run_matrix(1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        int s0;
        s0 = n_sclr;
        req_i = 1'b1;
        step();
        req_i = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            stream_valid_i = 1'b1;
            stream_data_i  = 16'($urandom);
            step();
        end
        stream_valid_i = 1'b0;
`ifdef SA_COLLECT_TIMEOUT_EN
        for (int i = 0; i < 7; i++) step();
        checks++;
        if (busy_o !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early got busy=%b err=%b exp 1 0", busy_o, err_o);
        end
        step();
        checks++;
        if (busy_o !== 1'b0 || err_o !== 1'b1 || stream_clr_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire got busy=%b err=%b stream_clr=%b exp 0 1 1", busy_o, err_o, stream_clr_o);
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (err_o !== 1'b1 || n_sclr - s0 != 1) begin
            errors++;
            $display("FAIL err_sticky got err=%b stream_clr=%0d exp 1 1", err_o, n_sclr - s0);
        end
        req_i = 1'b1;
        step();
        req_i = 1'b0;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got %b exp 0", err_o);
        end
`else
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (busy_o !== 1'b1 || err_o !== 1'b0 || n_sclr != s0) begin
            errors++;
            $display("FAIL no_timeout got busy=%b err=%b stream_clr=%0d exp 1 0 0", busy_o, err_o, n_sclr - s0);
        end
`endif
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        step();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cleanup got busy=%b exp 0", busy_o);
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_basic();
        test_gapped_backpressure();
        test_abort();
        test_stray_requests();
        test_random_back_to_back();
        test_mid_reset();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
